// File: rtl/zmod_tx_framer.sv
// zmod_tx_framer: transmit link framer in the byte-rate clock domain.
// Sends TRAIN_WORD until the PLL is locked and no retrain is requested, then
// packs 16-bit samples into frames of the form
//   FB, seq, {hi, lo} x FRAME_LEN, csum, FD
// with 8'hBC as idle and in-frame fill byte. Each state's byte is registered
// at the edge that ends that state's cycle, so the wire trails the state by
// one cycle. Losing lock anywhere outside TRAIN abandons the frame at once.
//
// Sample handshake: s_data is taken at a rising clk edge where both s_valid
// and s_ready are high. s_ready depends only on registered state and the
// synchronized lock, never on s_valid. The source may raise or drop s_valid
// at any time; a sample is consumed only on a valid&&ready edge.
module zmod_tx_framer #(
  parameter int         FRAME_LEN  = 16,
  parameter logic [7:0] TRAIN_WORD = 8'h0F
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pll_locked,
  input  logic        train_req,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  tx_word,
  output logic        tx_is_ctrl,
  output logic [15:0] frame_cnt,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    ST_TRAIN   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_HDR     = 3'd2,
    ST_SEQ     = 3'd3,
    ST_DATA_HI = 3'd4,
    ST_DATA_LO = 3'd5,
    ST_CSUM    = 3'd6,
    ST_END     = 3'd7
  } state_t;

  localparam logic [7:0] LEN8     = FRAME_LEN[7:0];
  localparam logic [7:0] IDLE_CHR = 8'hBC;
  localparam logic [7:0] HDR_CHR  = 8'hFB;
  localparam logic [7:0] END_CHR  = 8'hFD;

  state_t      state, state_n;
  logic        lock_meta, lock_s;
  logic [7:0]  csum, csum_n;
  logic [7:0]  cnt, cnt_n;
  logic [7:0]  lo_byte, lo_n;
  logic [7:0]  word_n;
  logic        ctrl_n;
  logic [15:0] fcnt_n;

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  // Next state, byte to emit and datapath updates; lock loss overrides all.
  always_comb begin
    state_n = state;
    word_n  = TRAIN_WORD;
    ctrl_n  = 1'b1;
    csum_n  = csum;
    cnt_n   = cnt;
    lo_n    = lo_byte;
    fcnt_n  = frame_cnt;
    if (state != ST_TRAIN && !lock_s) begin
      state_n = ST_TRAIN;
      lo_n    = 8'h00;
    end else begin
      case (state)
        ST_TRAIN: begin
          if (lock_s && !train_req) state_n = ST_IDLE;
        end
        ST_IDLE: begin
          word_n = IDLE_CHR;
          if (train_req)    state_n = ST_TRAIN;
          else if (s_valid) state_n = ST_HDR;
        end
        ST_HDR: begin
          word_n  = HDR_CHR;
          state_n = ST_SEQ;
        end
        ST_SEQ: begin
          word_n  = frame_cnt[7:0];
          ctrl_n  = 1'b0;
          csum_n  = frame_cnt[7:0];
          cnt_n   = 8'h00;
          state_n = ST_DATA_HI;
        end
        ST_DATA_HI: begin
          if (s_valid) begin
            word_n  = s_data[15:8];
            ctrl_n  = 1'b0;
            lo_n    = s_data[7:0];
            csum_n  = csum + s_data[15:8];
            state_n = ST_DATA_LO;
          end else begin
            word_n = IDLE_CHR;
          end
        end
        ST_DATA_LO: begin
          word_n  = lo_byte;
          ctrl_n  = 1'b0;
          csum_n  = csum + lo_byte;
          cnt_n   = cnt + 8'd1;
          state_n = (cnt_n == LEN8) ? ST_CSUM : ST_DATA_HI;
        end
        ST_CSUM: begin
          word_n  = csum;
          ctrl_n  = 1'b0;
          state_n = ST_END;
        end
        ST_END: begin
          word_n = END_CHR;
          fcnt_n = frame_cnt + 16'd1;
          if (train_req)    state_n = ST_TRAIN;
          else if (s_valid) state_n = ST_HDR;
          else              state_n = ST_IDLE;
        end
        default: state_n = ST_TRAIN;
      endcase
    end
  end

  // State, registered output byte and frame datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_TRAIN;
      tx_word    <= TRAIN_WORD;
      tx_is_ctrl <= 1'b1;
      csum       <= 8'h00;
      cnt        <= 8'h00;
      lo_byte    <= 8'h00;
      frame_cnt  <= 16'h0000;
    end else begin
      state      <= state_n;
      tx_word    <= word_n;
      tx_is_ctrl <= ctrl_n;
      csum       <= csum_n;
      cnt        <= cnt_n;
      lo_byte    <= lo_n;
      frame_cnt  <= fcnt_n;
    end
  end

  assign s_ready   = (state == ST_DATA_HI) && lock_s;
  assign busy      = (state != ST_TRAIN) && (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_zmod_tx_framer.sv
// Directed bench for zmod_tx_framer with FRAME_LEN=2.
module tb_zmod_tx_framer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pll_locked;
  logic        train_req;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  tx_word;
  logic        tx_is_ctrl;
  logic [15:0] frame_cnt;
  logic        busy;
  logic [2:0]  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0]  exp_q[$];   // {ctrl, byte} expected on the wire
  logic [15:0] samp_q[$];  // samples offered to the framer
  int          gap_arm;

  zmod_tx_framer #(.FRAME_LEN(2), .TRAIN_WORD(8'h0F)) dut (
    .clk(clk), .resetn(resetn), .pll_locked(pll_locked), .train_req(train_req),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .tx_word(tx_word), .tx_is_ctrl(tx_is_ctrl), .frame_cnt(frame_cnt),
    .busy(busy), .state_dbg(state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog expired tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Sample source: offers samp_q head, pops on handshake, optionally stalls
  // for gap_arm DATA_HI cycles after the next accepted sample.
  initial begin
    int  stall;
    logic acc;
    s_valid = 1'b0;
    s_data  = 16'h0000;
    stall   = 0;
    acc     = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (acc && samp_q.size() > 0) begin
        void'(samp_q.pop_front());
        if (gap_arm > 0) begin
          stall   = gap_arm;
          gap_arm = 0;
        end
      end
      if (stall > 0 && s_ready) begin
        s_valid = 1'b0;
        stall--;
      end else if (samp_q.size() > 0) begin
        s_valid = 1'b1;
        s_data  = samp_q[0];
      end else begin
        s_valid = 1'b0;
      end
      acc = s_valid && s_ready;
    end
  end

  // Queue a two-sample frame: samples to the source, bytes to the scoreboard.
  task automatic push_frame(input logic [7:0] seq, input logic [15:0] a,
                            input logic [15:0] b);
    logic [7:0] cs;
    cs = seq + a[15:8] + a[7:0] + b[15:8] + b[7:0];
    samp_q.push_back(a);
    samp_q.push_back(b);
    exp_q.push_back({1'b1, 8'hFB});
    exp_q.push_back({1'b0, seq});
    exp_q.push_back({1'b0, a[15:8]});
    exp_q.push_back({1'b0, a[7:0]});
    exp_q.push_back({1'b0, b[15:8]});
    exp_q.push_back({1'b0, b[7:0]});
    exp_q.push_back({1'b0, cs});
    exp_q.push_back({1'b1, 8'hFD});
  endtask

  // Wait for a header byte, then compare the wire against exp_q cycle by cycle.
  task automatic run_stream(input string tag, input int budget, input int tr_idx);
    bit         found;
    int         idx;
    logic [8:0] e;
    found = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (tx_is_ctrl && tx_word == 8'hFB) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, " hdr_seen"}, {31'd0, found}, 32'd1);
    idx = 0;
    while (exp_q.size() > 0) begin
      if (idx > 0) @(negedge clk);
      if (idx == tr_idx) train_req = 1'b1;
      e = exp_q.pop_front();
      check($sformatf("%s byte%0d", tag, idx), {23'd0, tx_is_ctrl, tx_word}, {23'd0, e});
      idx++;
    end
  endtask

  initial begin
    bit found;
    int k;
    resetn     = 1'b0;
    pll_locked = 1'b0;
    train_req  = 1'b0;
    gap_arm    = 0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst tx_word", {24'd0, tx_word}, 32'h0F);
    check("rst ctrl", {31'd0, tx_is_ctrl}, 32'd1);
    check("rst s_ready", {31'd0, s_ready}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("rst state", {29'd0, state_dbg}, 32'd0);
    resetn = 1'b1;

    // Unlocked: training only.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("train tx", {23'd0, tx_is_ctrl, tx_word}, {23'd0, 9'h10F});
      check("train s_ready", {31'd0, s_ready}, 32'd0);
    end

    // Lock: idle character after synchronizer plus output latency.
    pll_locked = 1'b1;
    found = 1'b0;
    k = 0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (tx_word == 8'hBC && tx_is_ctrl) begin
        found = 1'b1;
        k = n;
        break;
      end
      check("lock pre-idle tx", {24'd0, tx_word}, 32'h0F);
    end
    check("lock idle seen", {31'd0, found}, 32'd1);
    check("lock idle latency ok", {31'd0, (k >= 3 && k <= 4)}, 32'd1);
    @(negedge clk);
    check("idle tx", {23'd0, tx_is_ctrl, tx_word}, {23'd0, 9'h1BC});
    check("idle busy", {31'd0, busy}, 32'd0);

    // Frame 0, hand-computed bytes.
    samp_q.push_back(16'h1234);
    samp_q.push_back(16'hABCD);
    exp_q = '{9'h1FB, 9'h000, 9'h012, 9'h034, 9'h0AB, 9'h0CD, 9'h0BE, 9'h1FD};
    run_stream("f0", 10, -1);
    check("f0 frame_cnt", {16'd0, frame_cnt}, 32'd1);
    @(negedge clk);
    check("f0 after idle", {23'd0, tx_is_ctrl, tx_word}, {23'd0, 9'h1BC});
    check("f0 after busy", {31'd0, busy}, 32'd0);

    // Frame 1 with a three-cycle underrun after the first sample.
    gap_arm = 3;
    samp_q.push_back(16'h1234);
    samp_q.push_back(16'hABCD);
    exp_q = '{9'h1FB, 9'h001, 9'h012, 9'h034, 9'h1BC, 9'h1BC, 9'h1BC,
              9'h0AB, 9'h0CD, 9'h0BF, 9'h1FD};
    run_stream("f1gap", 10, -1);
    check("f1 frame_cnt", {16'd0, frame_cnt}, 32'd2);

    // Lock lost during the low byte of the first sample.
    samp_q.push_back(16'h1111);
    samp_q.push_back(16'h2222);
    found = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (state_dbg == 3'd5) begin
        found = 1'b1;
        break;
      end
    end
    check("drop at data_lo", {31'd0, found}, 32'd1);
    pll_locked = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (tx_word == 8'h0F && tx_is_ctrl) begin
        found = 1'b1;
        break;
      end
    end
    check("drop train within 3", {31'd0, found}, 32'd1);
    samp_q.delete();
    samp_q.push_back(16'h3333);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("unlocked tx", {23'd0, tx_is_ctrl, tx_word}, {23'd0, 9'h10F});
      check("unlocked s_ready", {31'd0, s_ready}, 32'd0);
      check("unlocked frame_cnt", {16'd0, frame_cnt}, 32'd2);
    end
    check("unlocked sample kept", samp_q.size(), 32'd1);
    samp_q.delete();
    push_frame(8'h02, 16'h5555, 16'h6666);
    pll_locked = 1'b1;
    run_stream("relock", 12, -1);
    check("relock frame_cnt", {16'd0, frame_cnt}, 32'd3);

    // Retrain requested mid-frame: frame completes, then training.
    push_frame(8'h03, 16'h0102, 16'h0304);
    run_stream("treq", 10, 1);
    check("treq frame_cnt", {16'd0, frame_cnt}, 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("treq train tx", {23'd0, tx_is_ctrl, tx_word}, {23'd0, 9'h10F});
      check("treq busy", {31'd0, busy}, 32'd0);
    end
    train_req = 1'b0;
    push_frame(8'h04, 16'h0506, 16'h0708);
    run_stream("post_treq", 10, -1);
    check("post_treq frame_cnt", {16'd0, frame_cnt}, 32'd5);

    // Reset, then 256 back-to-back frames with sequence wrap.
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("rst2 frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("rst2 tx", {23'd0, tx_is_ctrl, tx_word}, {23'd0, 9'h10F});
    check("rst2 busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    samp_q.delete();
    for (int f = 0; f < 256; f++) begin
      logic [7:0] f8;
      f8 = f[7:0];
      push_frame(f8, {f8, ~f8}, {f8 + 8'h11, 8'h80});
    end
    resetn = 1'b1;
    run_stream("b2b", 20, -1);
    check("b2b frame_cnt", {16'd0, frame_cnt}, 32'd256);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
